// File: rtl/cfu_requant_if.sv
// Custom-instruction cmd/rsp handshake bundle between the CPU (master) and
// the requantization CFU (slave).
`timescale 1ns/1ps
interface cfu_requant_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_requant.sv
// int32 accumulator -> int8 TFLite requantization CFU (bias, SRDHM, rounding shift,
// offset, clamp). Optional requant counter on ops 4/5 via CFU_REQUANT_COUNT_EN.
`timescale 1ns/1ps
module cfu_requant #(
    parameter logic signed [31:0] OUT_MIN_RST = -32'sd128,
    parameter logic signed [31:0] OUT_MAX_RST = 32'sd127
) (
    input  logic          clk,
    input  logic          reset_n,
    cfu_requant_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, SHIFT, RESP} state_t;
    state_t r_state, w_state_nxt;

    logic signed [31:0] r_mult, r_offset, r_act_min, r_act_max, r_acc, r_y;
    logic signed [5:0]  r_shift;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;

    logic [2:0]  w_op;
    logic        w_accept, w_rsp_done;
    logic [31:0] w_cfg_data;

    assign w_op       = bus.cmd_payload_function_id[2:0];
    assign w_accept   = bus.cmd_valid && (r_state == IDLE);
    assign w_rsp_done = r_rsp_valid && bus.rsp_ready;

    assign bus.cmd_ready             = (r_state == IDLE);
    assign bus.rsp_valid             = r_rsp_valid;
    assign bus.rsp_payload_outputs_0 = r_rsp_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_op == 3'd3) ? MUL : RESP;
            MUL:     w_state_nxt = SHIFT;
            SHIFT:   w_state_nxt = RESP;
            RESP:    if (w_rsp_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // MUL stage: optional left shift, then saturating rounding doubling high multiply.
    logic [4:0]         w_lsh;
    logic signed [31:0] w_x, w_srdhm;
    logic signed [63:0] w_p, w_nudge, w_sum, w_q;

    always_comb begin
        w_lsh   = r_shift[5] ? 5'd0 : r_shift[4:0];
        w_x     = r_acc << w_lsh;
        w_p     = $signed({{32{w_x[31]}}, w_x}) * $signed({{32{r_mult[31]}}, r_mult});
        w_nudge = w_p[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000;
        w_sum   = w_p + w_nudge;
        // Bias negative sums so the arithmetic shift truncates toward zero.
        w_q     = w_sum[63] ? ((w_sum + 64'sh0000_0000_7FFF_FFFF) >>> 31) : (w_sum >>> 31);
        w_srdhm = w_q[31:0];
        if (w_x == 32'sh8000_0000 && r_mult == 32'sh8000_0000) w_srdhm = 32'sh7FFF_FFFF;
    end

    // SHIFT stage: round-half-away-from-zero right shift, offset, clamp.
    logic [5:0]         w_e;
    logic [31:0]        w_mask, w_rem, w_thr;
    logic signed [31:0] w_ysh, w_z, w_o, w_clamp;

    always_comb begin
        w_e    = r_shift[5] ? 6'(-r_shift) : 6'd0;
        w_mask = (32'd1 << w_e) - 32'd1;
        w_rem  = r_y & w_mask;
        w_thr  = (w_mask >> 1) + {31'd0, r_y[31]};
        w_ysh  = r_y >>> w_e;
        w_z    = w_ysh + {31'd0, (w_rem > w_thr)};
        w_o    = w_z + r_offset;
        w_clamp = w_o;
        if (w_o < r_act_min)     w_clamp = r_act_min;
        if (w_clamp > r_act_max) w_clamp = r_act_max;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mult      <= '0;
            r_shift     <= '0;
            r_offset    <= '0;
            r_act_min   <= OUT_MIN_RST;
            r_act_max   <= OUT_MAX_RST;
            r_acc       <= '0;
            r_y         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                case (w_op)
                    3'd0: r_mult <= bus.cmd_payload_inputs_0;
                    3'd1: begin
                        r_shift  <= bus.cmd_payload_inputs_0[5:0];
                        r_offset <= bus.cmd_payload_inputs_1;
                    end
                    3'd2: begin
                        r_act_min <= bus.cmd_payload_inputs_0;
                        r_act_max <= bus.cmd_payload_inputs_1;
                    end
                    3'd3: r_acc <= bus.cmd_payload_inputs_0 + bus.cmd_payload_inputs_1;
                    default: ;
                endcase
                if (w_op != 3'd3) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_cfg_data;
                end
            end
            if (r_state == MUL) r_y <= w_srdhm;
            if (r_state == SHIFT) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_clamp;
            end
            if (w_rsp_done) r_rsp_valid <= 1'b0;
        end
    end

`ifdef CFU_REQUANT_COUNT_EN
    logic [31:0] r_cnt;
    logic        r_clr_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_clr_pend <= 1'b0;
        end else begin
            if (w_accept) r_clr_pend <= (w_op == 3'd5);
            if (w_accept && w_op == 3'd3) r_cnt <= r_cnt + 32'd1;
            if (w_rsp_done && r_clr_pend) r_cnt <= '0;
        end
    end

    assign w_cfg_data = (w_op == 3'd4 || w_op == 3'd5) ? r_cnt : '0;
`else
    assign w_cfg_data = '0;
`endif

    logic w_unused;
    assign w_unused = &{1'b0, bus.cmd_payload_function_id[9:3], w_q[63:32]};
endmodule

// File: tb/tb_cfu_requant.sv
// Directed self-checking bench for cfu_requant; expected values hand-computed.
`timescale 1ns/1ps
module tb_cfu_requant;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cfu_requant_if bus();

    cfu_requant #(.OUT_MIN_RST(-32'sd128), .OUT_MAX_RST(32'sd127)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Issue one command from IDLE, wait (bounded) for the response, then handshake it.
    // lat = rising edges from the accept edge through the edge raising rsp_valid.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat);
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = {7'h5A, op};
        bus.cmd_payload_inputs_0    = a;
        bus.cmd_payload_inputs_1    = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        data = bus.rsp_payload_outputs_0;
        if (!bus.rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout op=%0d: rsp_valid never rose within %0d cycles", op, lat);
        end else begin
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.cmd_payload_function_id = '0;
        bus.cmd_payload_inputs_0 = '0; bus.cmd_payload_inputs_1 = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_payload_outputs_0 !== 32'h0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", bus.rsp_payload_outputs_0); end
    endtask

    task automatic test_config_ack;
        logic [31:0] d; int lat;
        do_cmd(3'd1, 32'h0, 32'hFFFFFF80, d, lat);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL cfg1_data: got %h want 0", d); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL cfg1_latency: got %0d want 1", lat); end
        do_cmd(3'd0, 32'h40000000, 32'h0, d, lat);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL cfg0_data: got %h want 0", d); end
        do_cmd(3'd6, 32'h12345678, 32'h9ABCDEF0, d, lat);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL op6_data: got %h want 0", d); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL op6_latency: got %0d want 1", lat); end
    endtask

    task automatic test_requant_basic;
        logic [31:0] d; int lat;
        do_cmd(3'd3, 32'd100, 32'd0, d, lat);
        n_checks++; if (d !== 32'hFFFFFFB2) begin n_fail++; $display("FAIL rq_pos: got %h want ffffffb2", d); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rq_latency: got %0d want 3", lat); end
        do_cmd(3'd1, 32'h0, 32'h0, d, lat);
        do_cmd(3'd3, 32'hFFFFFF9C, 32'd0, d, lat);
        n_checks++; if (d !== 32'hFFFFFFCE) begin n_fail++; $display("FAIL rq_neg: got %h want ffffffce", d); end
        do_cmd(3'd0, 32'h80000000, 32'h0, d, lat);
        do_cmd(3'd3, 32'h80000000, 32'd0, d, lat);
        n_checks++; if (d !== 32'h0000007F) begin n_fail++; $display("FAIL rq_srdhm_sat: got %h want 0000007f", d); end
    endtask

    task automatic test_rounding_shift;
        logic [31:0] d; int lat;
        do_cmd(3'd1, 32'h3E, 32'h0, d, lat);
        do_cmd(3'd0, 32'h40000000, 32'h0, d, lat);
        do_cmd(3'd3, 32'd96, 32'd4, d, lat);
        n_checks++; if (d !== 32'h0000000D) begin n_fail++; $display("FAIL rshift2: got %h want 0000000d", d); end
        do_cmd(3'd1, 32'h3F, 32'h0, d, lat);
        do_cmd(3'd3, 32'd10, 32'd0, d, lat);
        n_checks++; if (d !== 32'h00000003) begin n_fail++; $display("FAIL rshift1_pos_tie: got %h want 00000003", d); end
        do_cmd(3'd3, 32'hFFFFFFF6, 32'd0, d, lat);
        n_checks++; if (d !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL rshift1_neg_tie: got %h want fffffffd", d); end
        do_cmd(3'd1, 32'h02, 32'h0, d, lat);
        do_cmd(3'd3, 32'd10, 32'd0, d, lat);
        n_checks++; if (d !== 32'h00000014) begin n_fail++; $display("FAIL lshift2: got %h want 00000014", d); end
    endtask

    task automatic test_clamp;
        logic [31:0] d; int lat;
        do_cmd(3'd1, 32'h0, 32'h0, d, lat);
        do_cmd(3'd0, 32'h7FFFFFFF, 32'h0, d, lat);
        do_cmd(3'd3, 32'd1000, 32'd0, d, lat);
        n_checks++; if (d !== 32'h0000007F) begin n_fail++; $display("FAIL clamp_max: got %h want 0000007f", d); end
        do_cmd(3'd2, 32'hFFFFFFF6, 32'd10, d, lat);
        do_cmd(3'd3, 32'hFFFFFC18, 32'd0, d, lat);
        n_checks++; if (d !== 32'hFFFFFFF6) begin n_fail++; $display("FAIL clamp_min: got %h want fffffff6", d); end
        do_cmd(3'd2, 32'd5, 32'd3, d, lat);
        do_cmd(3'd3, 32'hFFFFFC18, 32'd0, d, lat);
        n_checks++; if (d !== 32'h00000003) begin n_fail++; $display("FAIL clamp_inverted: got %h want 00000003", d); end
        do_cmd(3'd2, 32'hFFFFFF80, 32'd127, d, lat);
    endtask

    task automatic test_backpressure;
        logic [31:0] d; int lat;
        do_cmd(3'd0, 32'h40000000, 32'h0, d, lat);
        bus.cmd_valid = 1'b1; bus.cmd_payload_function_id = 10'd3;
        bus.cmd_payload_inputs_0 = 32'd100; bus.cmd_payload_inputs_1 = 32'd0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
            n_checks++; if (bus.rsp_payload_outputs_0 !== 32'h00000032) begin n_fail++; $display("FAIL bp_payload[%0d]: got %h want 00000032", i, bus.rsp_payload_outputs_0); end
            n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", i, bus.cmd_ready); end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_reset_midop;
        logic [31:0] d; int lat;
        do_cmd(3'd1, 32'h0, 32'd5, d, lat);
        do_cmd(3'd0, 32'h7FFFFFFF, 32'h0, d, lat);
        bus.cmd_valid = 1'b1; bus.cmd_payload_function_id = 10'd3;
        bus.cmd_payload_inputs_0 = 32'd1000; bus.cmd_payload_inputs_1 = 32'd0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_cmd_ready: got %b want 1", bus.cmd_ready); end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) reset_n = 1'b1;
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rsp_valid[%0d]: got %b want 0", i, bus.rsp_valid); end
            @(posedge clk); #1;
        end
        do_cmd(3'd3, 32'd1000, 32'd0, d, lat);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL abort_defaults: got %h want 0", d); end
    endtask

    task automatic test_counter;
        logic [31:0] d; int lat;
`ifdef CFU_REQUANT_COUNT_EN
        do_cmd(3'd5, 32'h0, 32'h0, d, lat);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL cnt_after_reset: got %h want 00000001", d); end
        for (int i = 0; i < 3; i++) do_cmd(3'd3, 32'd7, 32'd0, d, lat);
        do_cmd(3'd5, 32'h0, 32'h0, d, lat);
        n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL cnt_op5: got %h want 00000003", d); end
        do_cmd(3'd4, 32'h0, 32'h0, d, lat);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL cnt_op4_cleared: got %h want 0", d); end
        do_cmd(3'd3, 32'd7, 32'd0, d, lat);
        do_cmd(3'd4, 32'h0, 32'h0, d, lat);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL cnt_op4_read: got %h want 00000001", d); end
`else
        for (int i = 0; i < 3; i++) do_cmd(3'd3, 32'd7, 32'd0, d, lat);
        do_cmd(3'd4, 32'h0, 32'h0, d, lat);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL nocnt_op4: got %h want 0", d); end
        do_cmd(3'd5, 32'h0, 32'h0, d, lat);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL nocnt_op5: got %h want 0", d); end
`endif
    endtask

    initial begin
        test_reset();
        test_config_ack();
        test_requant_basic();
        test_rounding_shift();
        test_clamp();
        test_backpressure();
        test_reset_midop();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
